// File: rtl/axi_line_master_if.sv
// AXI4 bus bundle between the line master and its slave port.
// The master modport is the line master's view; the slave modport is the memory side.
interface axi_line_master_if #(
  parameter int unsigned AXI_ADDR_W = 64,
  parameter int unsigned AXI_ID_W   = 8,
  parameter int unsigned AXI_DATA_W = 64
) ();

  logic                    slv_awvalid;
  logic                    slv_awready;
  logic [AXI_ADDR_W-1:0]   slv_awaddr;
  logic [7:0]              slv_awlen;
  logic [2:0]              slv_awsize;
  logic [1:0]              slv_awburst;
  logic                    slv_awlock;
  logic [3:0]              slv_awcache;
  logic [2:0]              slv_awprot;
  logic [3:0]              slv_awqos;
  logic [3:0]              slv_awregion;
  logic [AXI_ID_W-1:0]     slv_awid;

  logic                    slv_wvalid;
  logic                    slv_wready;
  logic                    slv_wlast;
  logic [AXI_DATA_W-1:0]   slv_wdata;
  logic [AXI_DATA_W/8-1:0] slv_wstrb;

  logic                    slv_bvalid;
  logic                    slv_bready;
  logic [AXI_ID_W-1:0]     slv_bid;
  logic [1:0]              slv_bresp;

  logic                    slv_arvalid;
  logic                    slv_arready;
  logic [AXI_ADDR_W-1:0]   slv_araddr;
  logic [7:0]              slv_arlen;
  logic [2:0]              slv_arsize;
  logic [1:0]              slv_arburst;
  logic                    slv_arlock;
  logic [3:0]              slv_arcache;
  logic [2:0]              slv_arprot;
  logic [3:0]              slv_arqos;
  logic [3:0]              slv_arregion;
  logic [AXI_ID_W-1:0]     slv_arid;

  logic                    slv_rvalid;
  logic                    slv_rready;
  logic [AXI_ID_W-1:0]     slv_rid;
  logic [1:0]              slv_rresp;
  logic [AXI_DATA_W-1:0]   slv_rdata;
  logic                    slv_rlast;

  modport master (
    output slv_awvalid, slv_awaddr, slv_awlen, slv_awsize, slv_awburst, slv_awlock,
           slv_awcache, slv_awprot, slv_awqos, slv_awregion, slv_awid,
    input  slv_awready,
    output slv_wvalid, slv_wlast, slv_wdata, slv_wstrb,
    input  slv_wready,
    input  slv_bvalid, slv_bid, slv_bresp,
    output slv_bready,
    output slv_arvalid, slv_araddr, slv_arlen, slv_arsize, slv_arburst, slv_arlock,
           slv_arcache, slv_arprot, slv_arqos, slv_arregion, slv_arid,
    input  slv_arready,
    input  slv_rvalid, slv_rid, slv_rresp, slv_rdata, slv_rlast,
    output slv_rready
  );

  modport slave (
    input  slv_awvalid, slv_awaddr, slv_awlen, slv_awsize, slv_awburst, slv_awlock,
           slv_awcache, slv_awprot, slv_awqos, slv_awregion, slv_awid,
    output slv_awready,
    input  slv_wvalid, slv_wlast, slv_wdata, slv_wstrb,
    output slv_wready,
    output slv_bvalid, slv_bid, slv_bresp,
    input  slv_bready,
    input  slv_arvalid, slv_araddr, slv_arlen, slv_arsize, slv_arburst, slv_arlock,
           slv_arcache, slv_arprot, slv_arqos, slv_arregion, slv_arid,
    output slv_arready,
    output slv_rvalid, slv_rid, slv_rresp, slv_rdata, slv_rlast,
    input  slv_rready
  );

endinterface

// File: rtl/axi_line_master.sv
// Single-outstanding AXI4 master that reads or writes one whole line per request
// as a BEATS-long INCR burst, returning the line and an error flag on the response channel.
module axi_line_master #(
  parameter int unsigned          AXI_ADDR_W = 64,
  parameter int unsigned          AXI_ID_W   = 8,
  parameter int unsigned          AXI_DATA_W = 64,
  parameter int unsigned          BEATS      = 8,
  parameter logic [AXI_ID_W-1:0]  MST_ID     = '0
) (
  input  logic                          aclk,
  input  logic                          arst,

  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_write,
  input  logic [AXI_ADDR_W-1:0]         req_addr,
  input  logic [AXI_DATA_W*BEATS-1:0]   req_wdata,

  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic                          rsp_err,
  output logic [AXI_DATA_W*BEATS-1:0]   rsp_rdata,

  axi_line_master_if.master             axi
);

  localparam int unsigned LINE_W     = AXI_DATA_W * BEATS;
  localparam int unsigned LINE_BYTES = LINE_W / 8;
  localparam int unsigned OFF_W      = $clog2(LINE_BYTES);
  localparam int unsigned IDX_W      = $clog2(BEATS);
  localparam int unsigned CNT_W      = IDX_W + 1;
  localparam int unsigned SIZE       = $clog2(AXI_DATA_W / 8);

  localparam logic [CNT_W-1:0] LastBeat = CNT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0] BeatsCnt = CNT_W'(BEATS);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StAr   = 3'd1;
  localparam logic [2:0] StR    = 3'd2;
  localparam logic [2:0] StAw   = 3'd3;
  localparam logic [2:0] StW    = 3'd4;
  localparam logic [2:0] StB    = 3'd5;
  localparam logic [2:0] StResp = 3'd6;

  logic [2:0]                             state_q, state_d;
  logic [CNT_W-1:0]                       cnt_q, cnt_d;
  logic                                   err_q, err_d;
  logic [AXI_ADDR_W-1:0]                  addr_q, addr_d;
  logic [BEATS-1:0][AXI_DATA_W-1:0]       buf_q, buf_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    addr_d  = addr_q;
    buf_d   = buf_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          addr_d  = {req_addr[AXI_ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          buf_d   = req_wdata;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = req_write ? StAw : StAr;
        end
      end
      StAr: begin
        if (axi.slv_arready) begin
          cnt_d   = '0;
          state_d = StR;
        end
      end
      StR: begin
        if (axi.slv_rvalid) begin
          if (axi.slv_rresp[1] || (axi.slv_rid != MST_ID)) err_d = 1'b1;
          // Overrun beats are dropped and the counter parks at BEATS instead of wrapping.
          if (cnt_q < BeatsCnt) begin
            buf_d[cnt_q[IDX_W-1:0]] = axi.slv_rdata;
            cnt_d = cnt_q + 1'b1;
          end else begin
            err_d = 1'b1;
          end
          if (axi.slv_rlast) begin
            if (cnt_q != LastBeat) err_d = 1'b1;
            state_d = StResp;
          end
        end
      end
      StAw: begin
        if (axi.slv_awready) begin
          cnt_d   = '0;
          state_d = StW;
        end
      end
      StW: begin
        if (axi.slv_wready) begin
          if (cnt_q == LastBeat) state_d = StB;
          else                   cnt_d   = cnt_q + 1'b1;
        end
      end
      StB: begin
        if (axi.slv_bvalid) begin
          err_d   = axi.slv_bresp[1] | (axi.slv_bid != MST_ID);
          state_d = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          err_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (arst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Line buffer and address are pure datapath; reset leaves them untouched.
  always_ff @(posedge aclk) begin
    addr_q <= addr_d;
    buf_q  <= buf_d;
  end

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  assign rsp_err   = (state_q == StResp) & err_q;
  assign rsp_rdata = buf_q;

  assign axi.slv_awvalid  = (state_q == StAw);
  assign axi.slv_awaddr   = addr_q;
  assign axi.slv_awlen    = 8'(BEATS - 1);
  assign axi.slv_awsize   = 3'(SIZE);
  assign axi.slv_awburst  = 2'b01;
  assign axi.slv_awlock   = 1'b0;
  assign axi.slv_awcache  = 4'h0;
  assign axi.slv_awprot   = 3'h0;
  assign axi.slv_awqos    = 4'h0;
  assign axi.slv_awregion = 4'h0;
  assign axi.slv_awid     = MST_ID;

  assign axi.slv_wvalid = (state_q == StW);
  assign axi.slv_wdata  = buf_q[cnt_q[IDX_W-1:0]];
  assign axi.slv_wlast  = (state_q == StW) && (cnt_q == LastBeat);
  assign axi.slv_wstrb  = '1;

  assign axi.slv_bready = (state_q == StB);

  assign axi.slv_arvalid  = (state_q == StAr);
  assign axi.slv_araddr   = addr_q;
  assign axi.slv_arlen    = 8'(BEATS - 1);
  assign axi.slv_arsize   = 3'(SIZE);
  assign axi.slv_arburst  = 2'b01;
  assign axi.slv_arlock   = 1'b0;
  assign axi.slv_arcache  = 4'h0;
  assign axi.slv_arprot   = 3'h0;
  assign axi.slv_arqos    = 4'h0;
  assign axi.slv_arregion = 4'h0;
  assign axi.slv_arid     = MST_ID;

  assign axi.slv_rready = (state_q == StR);

  // Only the error bit of each response code matters to the line status.
  logic unused_resp_lsb;
  assign unused_resp_lsb = ^{axi.slv_rresp[0], axi.slv_bresp[0]};

endmodule

// File: doc/axi_line_master.md
AXI_LINE_MASTER -- requirements
Module: axi_line_master

Interface
REQ-001 Parameter AXI_ADDR_W, default 64, AXI address width in bits.
REQ-002 Parameter AXI_ID_W, default 8, AXI ID width in bits.
REQ-003 Parameter AXI_DATA_W, default 64, AXI data width in bits.
REQ-004 Parameter BEATS, default 8, beats per line, power of two, 2..256; LINE_W = AXI_DATA_W*BEATS; LINE_BYTES = LINE_W/8.
REQ-005 Parameter MST_ID, default 0, value driven on awid/arid.
REQ-006 aclk  in  1  single clock; all logic on rising edge.
REQ-007 arst  in  1  reset, synchronous, active-high.
REQ-008 req_valid in 1, req_ready out 1, req_write in 1 (1=write line), req_addr in AXI_ADDR_W, req_wdata in LINE_W: line request channel.
REQ-009 rsp_valid out 1, rsp_ready in 1, rsp_err out 1, rsp_rdata out LINE_W (beat 0 in bits [AXI_DATA_W-1:0]): line response channel.
REQ-010 AW out: slv_awvalid, slv_awaddr, slv_awlen[8], slv_awsize[3], slv_awburst[2], slv_awlock, slv_awcache[4], slv_awprot[3], slv_awqos[4], slv_awregion[4], slv_awid; in: slv_awready.
REQ-011 W out: slv_wvalid, slv_wlast, slv_wdata[AXI_DATA_W], slv_wstrb[AXI_DATA_W/8]; in: slv_wready.
REQ-012 B in: slv_bvalid, slv_bid, slv_bresp[2]; out: slv_bready.
REQ-013 AR out: slv_arvalid, slv_araddr, slv_arlen, slv_arsize, slv_arburst, slv_arlock, slv_arcache, slv_arprot, slv_arqos, slv_arregion, slv_arid; in: slv_arready.
REQ-014 R in: slv_rvalid, slv_rid, slv_rresp[2], slv_rdata, slv_rlast; out: slv_rready.

Function
REQ-015 States IDLE, AR, R, AW, W, B, RESP; one transaction outstanding at a time.
REQ-016 req_ready = (state==IDLE); on req_valid&req_ready latch req_write, req_wdata and addr with low log2(LINE_BYTES) bits cleared; next state AR (read) or AW (write).
REQ-017 Constant fields: len=BEATS-1, size=log2(AXI_DATA_W/8), burst=2'b01 INCR, lock/cache/prot/qos/region=0, id=MST_ID, wstrb all ones.
REQ-018 arvalid = (state==AR), awvalid = (state==AW); address/control stable while valid; never both asserted in the same cycle.
REQ-019 AR: on arready -> R, beat_cnt=0; AW: on awready -> W, beat_cnt=0.
REQ-020 R: rready=1; each rvalid beat writes rdata to buffer slot beat_cnt, beat_cnt+1; err |= rresp[1] | (rid!=MST_ID).
REQ-021 R terminates on the beat with rlast=1 -> RESP; err set if rlast beat is not beat BEATS-1; beats beyond BEATS-1 without rlast set err and are discarded.
REQ-022 W: wvalid=1, wdata=buffer slot beat_cnt, wlast=(beat_cnt==BEATS-1); on wready advance; last handshake -> B.
REQ-023 B: bready=1; on bvalid err = bresp[1] | (bid!=MST_ID) -> RESP.
REQ-024 RESP: rsp_valid=1, rsp_err=err, rsp_rdata=buffer (read data; write data echoed for writes); held stable until rsp_ready, then IDLE and err cleared.
REQ-025 Latency: request accept to arvalid/awvalid 1 cycle; last R/B handshake to rsp_valid 1 cycle; new request accepted the cycle after rsp handshake.
REQ-026 beat_cnt width log2(BEATS)+1; no wrap inside a burst.

Reset
REQ-027 arst high at a clock edge: state=IDLE, all valids/readies/rsp_valid/rsp_err/beat_cnt/err=0 next cycle, req_ready=1 after release; mid-burst aborted without completion; line buffer not cleared.

Verification
REQ-028 Read req_addr 0x8000_0040 -> araddr 0x8000_0040, arlen 7, arsize 3, arburst 1; rdata 0..7, rlast on 8th -> rsp_rdata beat i = i, rsp_err 0.
REQ-029 Write req_addr 0x8000_007C -> awaddr 0x8000_0040; 8 W beats, wstrb 0xFF, wlast only on 8th; bresp 0 -> rsp_err 0.
REQ-030 Read with rresp=2'b10 on beat 3 -> all 8 beats accepted, rsp_err 1.
REQ-031 rlast on beat 5 -> RESP after 6 beats, rsp_err 1.
REQ-032 arready delayed 4 cycles, rsp_ready low 3 cycles -> araddr stable, rsp_valid/rsp_rdata held, req_ready 0 throughout.
REQ-033 arst asserted in W after 3 beats -> next cycle wvalid 0, awvalid 0, rsp_valid 0; req_ready 1 after release.
